mult_unit: RTL
==============

# mult_unit

Multi-cycle shift-add multiplier that sits directly downstream of the register file in the pico-MIPS datapath. It consumes the two register read ports (`Rs_data`, `Rd_data`, low `N` bits) when the controller issues a multiply, and produces a `2N`-bit product for the writeback mux. It stalls the controller through `busy` and signals completion with a one-cycle `done` pulse.

## Interface
- `N`, default 8: operand width in bits. Legal range is 2 to 32. The product width is `2N`.
- `CW`, default `$clog2(N)+1`: iteration counter width. Derived from `N`; do not override.
- `clk`  in  1: system clock. All state changes on the rising edge.
- `n_reset`  in  1: asynchronous, active-low reset. One clock domain; reset is asserted asynchronously and released synchronously to `clk` by the top level.
- `start`  in  1: request a multiply. Sampled only in IDLE or DONE.
- `a`  in  N: multiplicand, driven from `Rs_data[N-1:0]`.
- `b`  in  N: multiplier, driven from `Rd_data[N-1:0]`.
- `busy`  out  1: high while in RUN. The controller holds the PC and `w_enable` low while `busy` is high.
- `done`  out  1: one-cycle pulse meaning `result` is valid. The controller drives the register-file write on this cycle.
- `result`  out  2N: product. Holds its value until the next accepted `start`.

## Operation
- FSM states are IDLE, RUN and DONE. The reset state is IDLE.
- IDLE, with `start` = 1: latch operands, clear the accumulator and counter, then go to RUN.
- IDLE, with `start` = 0: stay in IDLE.
- RUN:
  - Each cycle, if the multiplier LSB is 1, then accumulator += multiplicand.
  - The multiplicand (held in 2N bits) shifts left by 1.
  - The multiplier shifts right by 1.
  - The counter increments.
- RUN exit: when the counter reaches N-1 on an edge, finish that iteration, register `result`, and go to DONE.
- DONE: `done` = 1 for exactly one cycle.
  - `start` = 1: accept new operands and go to RUN (back-to-back operation).
  - `start` = 0: go to IDLE.
- `start` in RUN is ignored. There is no queueing, and the latched operands are unaffected.
- `a` and `b` are sampled only on the accepting edge. Later changes have no effect on the operation in flight.
- Arithmetic is unsigned, modulo nothing: the full `2N`-bit product is always exact. All intermediate registers are `2N` bits wide.
- Reset values: `busy` = 0, `done` = 0, `result` = 0, and all internal registers = 0.
- Reset mid-operation aborts immediately: the block returns to IDLE with outputs at their reset values. The next `start` after release behaves exactly as after power-up.

## Timing
- Accepting edge k: `busy` rises after edge k.
- `busy` stays high for N cycles, after edges k through k+N-1.
- After edge k+N: `busy` = 0, `done` = 1, and `result` holds the valid product. Latency is N cycles from accept to `done`.
- After edge k+N+1: `done` = 0 and `result` is unchanged.
- Maximum throughput is one product per N+1 cycles, when `start` is held high.
- `done` and `busy` are never high in the same cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `MULT_SIGNED_EN` defined: operands are two's complement and `result` is the signed `2N`-bit product.
  - The accepting edge latches the magnitudes of the operands (N-bit unsigned, so -2^(N-1) maps to 2^(N-1)) and a sign flag, sign(a) XOR sign(b).
  - RUN is unchanged.
  - On the edge entering DONE, the product is negated when the sign flag is 1.
  - Latency is unchanged.
- `MULT_SIGNED_EN` not defined: operands and result are unsigned. No sign logic is synthesised.

## Test plan
- Unsigned basic: N=8, a=13, b=11, one-cycle `start` → `busy` high for 8 cycles, then `done` for 1 cycle with `result` = 0x008F; `result` then holds 0x008F.
- Unsigned extremes: a=255, b=255 → 0xFE01. a=0, b=200 → 0x0000 with the same 8-cycle latency. Without the macro, a=0xFD, b=0x05 → 0x04F1.
- Busy protection: accept a=7, b=9; in RUN cycle 3 pulse `start` with a=1, b=1 → `result` = 0x003F. `done` pulses once, and no second operation starts.
- Back-to-back: hold `start` high with a=2, b=3 then a=4, b=5 → `done` after 8 cycles with 0x0006; RUN re-entered directly from DONE; second `done` 9 cycles later with 0x0014.
- Reset mid-op: accept a=100, b=100; deassert `n_reset` in RUN cycle 4 → `busy`, `done` and `result` go to 0 immediately. After release, a=3, b=3 → 0x0009 after 8 cycles.
- Signed (`MULT_SIGNED_EN`):
  - a=-3 (0xFD), b=5 → 0xFFF1.
  - a=-128, b=-128 → 0x4000.
  - a=127, b=-1 → 0xFF81.
  - Latency is 8 cycles in every case.

Source files
------------

// File: rtl/mult_unit.sv
// mult_unit: multi-cycle shift-add multiplier producing a 2N-bit product with busy/done handshake.
// Optional MULT_SIGNED_EN: two's-complement operands, sign applied to the magnitude product.
module mult_unit #(
    parameter int N  = 8,
    parameter int CW = $clog2(N) + 1
) (
    input  logic           clk,
    input  logic           n_reset,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] result
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [2*N-1:0] acc, mcand, acc_nx, prod;
    logic [N-1:0] mplier, mag_a, mag_b;
    logic [CW-1:0] cnt;
    logic last, accept;

    assign last   = cnt == CW'(N - 1);
    assign accept = start && state != RUN;
    assign acc_nx = acc + (mplier[0] ? mcand : '0);

`ifdef MULT_SIGNED_EN
    logic neg, sign_in;
    // Magnitudes are N-bit unsigned, so the most negative value maps to 2^(N-1).
    assign mag_a   = a[N-1] ? -a : a;
    assign mag_b   = b[N-1] ? -b : b;
    assign sign_in = a[N-1] ^ b[N-1];
    assign prod    = neg ? -acc_nx : acc_nx;
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)
            neg <= 1'b0;
        else if (accept)
            neg <= sign_in;
    end
`else
    assign mag_a = a;
    assign mag_b = b;
    assign prod  = acc_nx;
`endif

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: state_nx = start ? RUN : IDLE;
            RUN: begin
                state_nx = last ? DONE : RUN;
                busy     = 1'b1;
            end
            DONE: begin
                state_nx = start ? RUN : IDLE;
                done     = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    // The final iteration's sum is folded straight into result on the edge entering DONE.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            result <= '0;
        end else if (accept) begin
            acc    <= '0;
            mcand  <= {{N{1'b0}}, mag_a};
            mplier <= mag_b;
            cnt    <= '0;
        end else if (state == RUN) begin
            acc    <= acc_nx;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (last)
                result <= prod;
        end
    end
endmodule
